// File: rtl/split_add_pkg.sv
// Shared types and constants for the split add/sub pipeline.
package split_add_pkg;

  // Operation selector carried alongside each operand word.
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Stage 0 holds the operands and stage 1 holds the result, so two stages are the floor.
  localparam int unsigned MIN_STAGES = 2;

endpackage

// File: rtl/split_add_stage.sv
// One valid/ready pipeline register. It loads whenever it is empty or its consumer is
// taking the current word, so an empty slot never blocks traffic behind it.
module split_add_stage #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [DW-1:0] up_data,
  output logic          dn_valid,
  input  logic          dn_ready,
  output logic [DW-1:0] dn_data
);

  logic          valid_q;
  logic [DW-1:0] data_q;
  logic          load;

  // Empty stages always load so bubbles collapse even while the output is stalled.
  assign load     = !valid_q || dn_ready;
  assign up_ready = load;
  assign dn_valid = valid_q;
  assign dn_data  = data_q;

  // Valid follows upstream on load; data only moves with a real word so idle X never enters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= up_valid;
      if (up_valid) begin
        data_q <= up_data;
      end
    end
  end

endmodule

// File: rtl/split_add_pipe.sv
// Pipelined split adder: each input word carries operands {a, b} and an op bit.
// Stage 0 registers the operands, the add/sub sits between stage 0 and stage 1, and the
// remaining stages only delay {carry, result}. Outputs come straight from the last stage.
module split_add_pipe
  import split_add_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] s,
  input  logic               in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out,
  output logic               out_carry
);

  localparam int unsigned OpDw  = 2 * WIDTH + 1;
  localparam int unsigned ResDw = WIDTH + 1;

  if (STAGES < MIN_STAGES) begin : g_bad_stages
    $error("split_add_pipe: STAGES must be at least %0d", MIN_STAGES);
  end

  // Stage 0: {a, b, op}
  logic            s0_ready;
  logic            s0_valid;
  logic [OpDw-1:0] s0_data;
  logic            s1_ready;

  split_add_stage #(
    .DW (OpDw)
  ) u_stage0 (
    .clk      (clk),
    .rst      (rst),
    .up_valid (in_valid),
    .up_ready (s0_ready),
    .up_data  ({s, in_op}),
    .dn_valid (s0_valid),
    .dn_ready (s1_ready),
    .dn_data  (s0_data)
  );

  // Nothing is accepted while reset is held, even though stage 0 is empty.
  assign in_ready = s0_ready && !rst;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] op_b_eff;
  op_e              op_sel;
  logic             is_sub;
  logic [WIDTH:0]   sum;
  logic [ResDw-1:0] sum_res;

  // Add or subtract the registered operands; subtraction is a + ~b + 1 with carry inverted.
  always_comb begin
    op_a     = s0_data[OpDw-1:WIDTH+1];
    op_b     = s0_data[WIDTH:1];
    op_sel   = op_e'(s0_data[0]);
    is_sub   = (op_sel == OP_SUB);
    op_b_eff = is_sub ? ~op_b : op_b;
    sum      = {1'b0, op_a} + {1'b0, op_b_eff} + {{WIDTH{1'b0}}, is_sub};
    sum_res  = {sum[WIDTH] ^ is_sub, sum[WIDTH-1:0]};
  end

  // Result stages 1..STAGES-1; each keeps its own handshake wires to avoid a flat ready loop.
  for (genvar k = 1; k < STAGES; k++) begin : g_res
    logic             up_vld;
    logic             up_rdy;
    logic [ResDw-1:0] up_dat;
    logic             dn_vld;
    logic             dn_rdy;
    logic [ResDw-1:0] dn_dat;

    if (k == 1) begin : g_first
      assign up_vld   = s0_valid;
      assign up_dat   = sum_res;
      assign s1_ready = up_rdy;
    end else begin : g_mid
      assign up_vld = g_res[k-1].dn_vld;
      assign up_dat = g_res[k-1].dn_dat;
    end

    if (k == STAGES - 1) begin : g_last
      assign dn_rdy    = out_ready;
      assign out_valid = dn_vld;
      assign out       = dn_dat[WIDTH-1:0];
      assign out_carry = dn_dat[WIDTH];
    end else begin : g_next
      assign dn_rdy = g_res[k+1].up_rdy;
    end

    split_add_stage #(
      .DW (ResDw)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .up_valid (up_vld),
      .up_ready (up_rdy),
      .up_data  (up_dat),
      .dn_valid (dn_vld),
      .dn_ready (dn_rdy),
      .dn_data  (dn_dat)
    );
  end

endmodule

// File: tb/tb_split_add_pipe.sv
// Bench for split_add_pipe: four instances (32/2, 32/4, 1/2, 64/5) share one driver and a
// queue-based reference; sel picks which instance is exercised, the rest sit idle draining.
module tb_split_add_pipe;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  int           sel;
  logic         drv_valid;
  logic         drv_op;
  logic         drv_ordy;
  logic [127:0] drv_s;

  always #5 clk = ~clk;

  logic        a_ir, a_ov, a_oc;
  logic [31:0] a_out;
  logic        b_ir, b_ov, b_oc;
  logic [31:0] b_out;
  logic        c_ir, c_ov, c_oc;
  logic [0:0]  c_o1;
  logic        d_ir, d_ov, d_oc;
  logic [63:0] d_out;

  split_add_pipe #(.WIDTH(32), .STAGES(2)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(drv_valid && sel == 0), .in_ready(a_ir),
    .s(drv_s[63:0]), .in_op(drv_op), .out_valid(a_ov),
    .out_ready(sel == 0 ? drv_ordy : 1'b1), .out(a_out), .out_carry(a_oc)
  );
  split_add_pipe #(.WIDTH(32), .STAGES(4)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(drv_valid && sel == 1), .in_ready(b_ir),
    .s(drv_s[63:0]), .in_op(drv_op), .out_valid(b_ov),
    .out_ready(sel == 1 ? drv_ordy : 1'b1), .out(b_out), .out_carry(b_oc)
  );
  split_add_pipe #(.WIDTH(1), .STAGES(2)) u_dut_c (
    .clk(clk), .rst(rst), .in_valid(drv_valid && sel == 2), .in_ready(c_ir),
    .s(drv_s[1:0]), .in_op(drv_op), .out_valid(c_ov),
    .out_ready(sel == 2 ? drv_ordy : 1'b1), .out(c_o1), .out_carry(c_oc)
  );
  split_add_pipe #(.WIDTH(64), .STAGES(5)) u_dut_d (
    .clk(clk), .rst(rst), .in_valid(drv_valid && sel == 3), .in_ready(d_ir),
    .s(drv_s), .in_op(drv_op), .out_valid(d_ov),
    .out_ready(sel == 3 ? drv_ordy : 1'b1), .out(d_out), .out_carry(d_oc)
  );

  logic        m_in_ready, m_out_valid, m_carry;
  logic [63:0] m_out;

  // Route the selected instance onto the common observation wires.
  always_comb begin
    m_in_ready = d_ir; m_out_valid = d_ov; m_carry = d_oc; m_out = d_out;
    case (sel)
      0: begin m_in_ready = a_ir; m_out_valid = a_ov; m_carry = a_oc; m_out = {32'd0, a_out}; end
      1: begin m_in_ready = b_ir; m_out_valid = b_ov; m_carry = b_oc; m_out = {32'd0, b_out}; end
      2: begin m_in_ready = c_ir; m_out_valid = c_ov; m_carry = c_oc; m_out = {63'd0, c_o1}; end
      default: ;
    endcase
  end

  typedef struct {
    logic [64:0] exp;
    int          acc;
  } ent_t;

  ent_t  q[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    W, S;
  int    cyc = 0;
  int    last_dep = -1;
  int    last_out_cyc = 0;
  int    ndone = 0;
  bit    accepted;
  string cur = "init";

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: {carry/borrow, result mod 2^w} straight from the arithmetic definition.
  function automatic logic [64:0] ref_calc(input logic [63:0] a, input logic [63:0] b,
                                           input bit op, input int w);
    logic [64:0] m;
    logic [64:0] r;
    logic [64:0] res;
    m = (65'd1 << w) - 65'd1;
    if (!op) begin
      r      = {1'b0, a} + {1'b0, b};
      res    = r & m;
      res[64] = r[w];
    end else begin
      r      = {1'b0, a} - {1'b0, b};
      res    = r & m;
      res[64] = (a < b);
    end
    return res;
  endfunction

  function automatic logic [127:0] mk_s(input logic [63:0] a, input logic [63:0] b, input int w);
    return ({64'd0, a} << w) | {64'd0, b};
  endfunction

  task automatic select_dut(input int k);
    sel = k;
    case (k)
      0: begin W = 32; S = 2; end
      1: begin W = 32; S = 4; end
      2: begin W = 1;  S = 2; end
      default: begin W = 64; S = 5; end
    endcase
    last_dep = -1;
  endtask

  // One clock: drive at the falling edge, then compare against the queue model.
  task automatic step(input bit v, input logic [127:0] s_in, input bit op, input bit ordy,
                      input logic [64:0] exp_given, input bit use_given);
    int   t0;
    bit   exp_ov;
    ent_t e;
    @(negedge clk);
    drv_valid = v; drv_s = s_in; drv_op = op; drv_ordy = ordy;
    #1;
    check_eq({cur, "/in_ready"}, m_in_ready, (q.size() < S) || ordy);
    exp_ov = 1'b0;
    if (q.size() != 0) begin
      t0 = q[0].acc + S;
      if (last_dep + 1 > t0) t0 = last_dep + 1;
      exp_ov = (cyc >= t0);
    end
    check_eq({cur, "/out_valid"}, m_out_valid, exp_ov);
    if (m_out_valid && q.size() != 0) begin
      check_eq({cur, "/result"}, {m_carry, m_out}, q[0].exp);
      if (ordy) begin
        void'(q.pop_front());
        last_dep = cyc;
        last_out_cyc = cyc;
        ndone++;
      end
    end
    accepted = v && m_in_ready;
    if (accepted) begin
      e.exp = use_given ? exp_given
                        : ref_calc(64'(s_in >> W) & ((W == 64) ? '1 : ((64'd1 << W) - 64'd1)),
                                   s_in[63:0] & ((W == 64) ? '1 : ((64'd1 << W) - 64'd1)), op, W);
      e.acc = cyc;
      q.push_back(e);
    end
    cyc++;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) step(1'b0, '0, 1'b0, 1'b1, '0, 1'b0);
    check_eq({cur, "/drained"}, q.size(), 0);
  endtask

  task automatic send_one(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input bit op, input logic [64:0] exp);
    int acc_c;
    cur = tag;
    step(1'b1, mk_s(a, b, W), op, 1'b1, exp, 1'b1);
    check_eq({tag, "/accept"}, accepted, 1);
    acc_c = cyc - 1;
    drain();
    check_eq({tag, "/latency"}, last_out_cyc - acc_c, S);
  endtask

  task automatic rand_run(input string tag, input int n);
    logic [63:0] m, a, b;
    cur = tag;
    m = (W == 64) ? '1 : ((64'd1 << W) - 64'd1);
    for (int i = 0; i < n; i++) begin
      a = {$urandom, $urandom} & m;
      b = {$urandom, $urandom} & m;
      step($urandom_range(0, 3) != 0, mk_s(a, b, W), 1'($urandom_range(0, 1)),
           $urandom_range(0, 2) != 0, '0, 1'b0);
    end
    drain();
  endtask

  initial begin
    int idx, base, start_done;
    drv_valid = 1'b0; drv_op = 1'b0; drv_ordy = 1'b1; drv_s = '0;
    select_dut(0);

    // Reset state
    #1;
    check_eq("rst/out_valid", m_out_valid, 0);
    check_eq("rst/out", m_out, 0);
    check_eq("rst/carry", m_carry, 0);
    check_eq("rst/in_ready", m_in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst/ready_after", m_in_ready, 1);

    // Directed add/sub on 32-bit, two-stage instance
    send_one("add_basic", 64'd3, 64'd5, 1'b0, {1'b0, 64'h8});
    send_one("add_ovf", 64'hFFFF_FFFF, 64'd1, 1'b0, {1'b1, 64'h0});
    send_one("sub_pos", 64'd5, 64'd3, 1'b1, {1'b0, 64'h2});
    send_one("sub_neg", 64'd3, 64'd5, 1'b1, {1'b1, 64'hFFFF_FFFE});
    rand_run("rand_a", 150);

    // Stall and backpressure on the four-stage instance
    select_dut(1);
    cur = "stall";
    idx = 0;
    base = cyc;
    start_done = ndone;
    for (int t = 0; t < 60 && (ndone - start_done) < 10; t++) begin
      step(idx < 10, mk_s(64'(idx), 64'd100, W), 1'b0, !(t >= 3 && t <= 12),
           {1'b0, 64'(100 + idx)}, 1'b1);
      if (t == 4) check_eq("stall/in_ready_drop", m_in_ready, 0);
      if (accepted) idx++;
    end
    check_eq("stall/count", ndone - start_done, 10);
    check_eq("stall/last_out_cycle", last_out_cyc - base, 22);
    drain();

    // Asynchronous reset with three words in flight
    cur = "midrst";
    for (int i = 0; i < 3; i++) step(1'b1, mk_s(64'(i + 7), 64'd1, W), 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    check_eq("midrst/pre_valid", m_out_valid, 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("midrst/out_valid", m_out_valid, 0);
    check_eq("midrst/out", m_out, 0);
    check_eq("midrst/carry", m_carry, 0);
    check_eq("midrst/in_ready", m_in_ready, 0);
    q.delete();
    last_dep = -1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("midrst/ready_after", m_in_ready, 1);
    send_one("midrst_new", 64'd1, 64'd1, 1'b0, {1'b0, 64'd2});
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b0, 1'b1, '0, 1'b0);

    // One-bit instance: all add/sub operand cases, then random traffic
    select_dut(2);
    send_one("w1_add00", 64'd0, 64'd0, 1'b0, {1'b0, 64'd0});
    send_one("w1_add01", 64'd0, 64'd1, 1'b0, {1'b0, 64'd1});
    send_one("w1_add10", 64'd1, 64'd0, 1'b0, {1'b0, 64'd1});
    send_one("w1_add11", 64'd1, 64'd1, 1'b0, {1'b1, 64'd0});
    send_one("w1_sub00", 64'd0, 64'd0, 1'b1, {1'b0, 64'd0});
    send_one("w1_sub01", 64'd0, 64'd1, 1'b1, {1'b1, 64'd1});
    send_one("w1_sub10", 64'd1, 64'd0, 1'b1, {1'b0, 64'd1});
    send_one("w1_sub11", 64'd1, 64'd1, 1'b1, {1'b0, 64'd0});
    rand_run("rand_w1", 300);

    // 64-bit, five-stage instance
    select_dut(3);
    send_one("w64_ovf", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, {1'b1, 64'd0});
    send_one("w64_sub", 64'd0, 64'd1, 1'b1, {1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
    rand_run("rand_w64", 400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
